// File: rtl/pcie_ingress_ctrl_if.sv
// Source-side handshake bundle for the PCIe ingress flow controller.
// The traffic source drives valid/data through the master modport, and the
// controller answers with ready through the slave modport.
interface pcie_ingress_ctrl_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_ready;

    modport master (
        output src_valid,
        output src_data,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_data,
        output src_ready
    );
endinterface

// File: rtl/pcie_ingress_ctrl.sv
// Ingress flow controller in front of the PCIe transaction block's main FIFO.
// Words from the source land in a small circular skid buffer and are drained
// one per cycle into push/data_in_principal. Draining stops while the main
// FIFO asks for a pause or the init window is open. The block also reports
// its FSM state, idle/error status and a running count of pushed words.
module pcie_ingress_ctrl #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    pcie_ingress_ctrl_if.slave     src,
    input  logic                   pausa_mf,
    output logic                   push,
    output logic [DATA_WIDTH-1:0]  data_in_principal,
    output logic [PTR_WIDTH:0]     buf_count,
    output logic [7:0]             sent_count,
    output logic [1:0]             state,
    output logic                   idle_out,
    output logic                   error_out
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    localparam int CNT_W = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0]   FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

    state_t                state_reg;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_reg;
    logic [PTR_WIDTH-1:0]  rd_ptr_reg;
    logic [PTR_WIDTH:0]    count_reg;
    logic [PTR_WIDTH:0]    count_next;
    logic                  push_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [7:0]            sent_reg;
    logic                  idle_reg;
    logic                  error_reg;
    logic                  ready;
    logic                  accept;
    logic                  drain;

    // Handshake and drain qualifiers. Ready looks only at the current
    // occupancy, so a full buffer refuses a word even when a drain happens
    // in the same cycle (no bypass path).
    always_comb begin
        ready  = ((state_reg == ST_IDLE) || (state_reg == ST_ACTIVE))
                 && (count_reg < FULL_COUNT) && !init && !reset;
        accept = src.src_valid && ready;
        drain  = (state_reg == ST_ACTIVE) && (count_reg != '0)
                 && !pausa_mf && !init;
    end

    assign src.src_ready = ready;

    // Occupancy after this edge; a simultaneous accept and drain cancel out.
    always_comb begin
        count_next = count_reg;
        case ({accept, drain})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Next FSM state. An open init window overrides everything except the
    // mandatory RESET -> INIT step; buffered words stay put across it.
    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_RESET) begin
            state_next = ST_INIT;
        end else if (init) begin
            state_next = ST_INIT;
        end else begin
            case (state_reg)
                ST_INIT:   state_next = (count_reg != '0) ? ST_ACTIVE : ST_IDLE;
                ST_IDLE:   if (accept) state_next = ST_ACTIVE;
                ST_ACTIVE: if (count_next == '0) state_next = ST_IDLE;
                default:   state_next = state_reg;
            endcase
        end
    end

    // Skid-buffer storage: written on accept, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= src.src_data;
        end
    end

    // FSM, pointers, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_RESET;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            push_reg   <= 1'b0;
            data_reg   <= '0;
            sent_reg   <= 8'd0;
            idle_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idle_reg  <= (state_next == ST_IDLE);
            count_reg <= count_next;
            push_reg  <= drain;
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (drain) begin
                data_reg   <= mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                sent_reg   <= sent_reg + 8'd1;
            end
            // A source presenting data during configuration is a protocol
            // violation; the flag stays up until the next reset.
            if (src.src_valid && (state_reg == ST_INIT)) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign state             = state_reg;
    assign push              = push_reg;
    assign data_in_principal = data_reg;
    assign buf_count         = count_reg;
    assign sent_count        = sent_reg;
    assign idle_out          = idle_reg;
    assign error_out         = error_reg;

endmodule
